// File: rtl/boot_pkg.sv
// Shared constants for the UART boot sequencer:
// FSM state encodings, reply codes and the default frame sync byte.
package boot_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_REPLY  = 3'd5;
  localparam logic [2:0] ST_RUN    = 3'd6;

  localparam logic [7:0] ACK_CODE     = 8'h06;
  localparam logic [7:0] NAK_CODE     = 8'h15;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/boot_timeout_counter.sv
// Inter-byte idle counter. Ports: clk, rst (async high), clear,
// enable (count while set), expired (count reached TIMEOUT_CYC).
module boot_timeout_counter #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT_CYC));

  // Saturates at the limit so expiry stays visible until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && !expired)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_boot_sequencer.sv
// Boot loader: receives SYNC/LEN/data/CHK frames over UART, writes imem,
// replies ACK/NAK, then releases cpu_reset. Ports: UART rx/tx, imem write, boot_req.
module uart_boot_sequencer import boot_pkg::*; #(
  parameter int         ADDR_W      = 8,
  parameter int         MAX_WORDS   = 256,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err_timeout
);

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              txv_q, txv_d;
  logic [7:0]        txd_q, txd_d;
  logic              err_q, err_d;

  logic        timed;
  logic        tmo_expired;
  logic [15:0] n_rx;
  logic [15:0] idx_nx;

  assign n_rx   = {len_hi_q, rx_data};
  assign idx_nx = idx_q + 16'd1;
  assign timed  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                  (state_q == ST_DATA)   || (state_q == ST_CHECK);

  boot_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (CLK),
    .rst    (reset),
    .clear  (rx_valid || (state_d != state_q)),
    .enable (timed),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    word_d   = word_q;
    sum_d    = sum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    txv_d    = txv_q;
    txd_d    = txd_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN_HI;
          sum_d   = '0;
          idx_d   = '0;
          lane_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_hi_d = rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_d = n_rx;
          if (n_rx == 16'd0) begin
            state_d = ST_CHECK;
          end else if (n_rx > 16'(MAX_WORDS)) begin
            state_d = ST_REPLY;
            txv_d   = 1'b1;
            txd_d   = NAK_CODE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          sum_d  = sum_q + rx_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(idx_q);
            wdata_d = {rx_data, word_q};
            idx_d   = idx_nx;
            if (idx_nx == len_q)
              state_d = ST_CHECK;
          end else begin
            word_d[8*lane_q +: 8] = rx_data;
          end
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          state_d = ST_REPLY;
          txv_d   = 1'b1;
          txd_d   = (rx_data == sum_q) ? ACK_CODE : NAK_CODE;
        end
      end
      ST_REPLY: begin
        if (txv_q && tx_ready) begin
          txv_d   = 1'b0;
          state_d = (txd_q == ACK_CODE) ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (boot_req)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte arriving on the expiry cycle keeps the frame alive.
    if (timed && !rx_valid && tmo_expired) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      sum_q    <= sum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
      err_q    <= err_d;
    end
  end

  assign tx_valid    = txv_q;
  assign tx_data     = txd_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset   = (state_q != ST_RUN);
  assign busy        = timed || (state_q == ST_REPLY);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Scoreboard bench for uart_boot_sequencer: expected imem writes and
// tx bytes are queued when frames are sent and popped by a monitor.
module tb_uart_boot_sequencer;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        boot_req = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        err_timeout;

  int tests_run = 0;
  int failed = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] img[$];

  always #5 CLK = ~CLK;

  uart_boot_sequencer #(
    .ADDR_W(8), .MAX_WORDS(256), .TIMEOUT_CYC(100), .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK(CLK), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .boot_req(boot_req),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .err_timeout(err_timeout)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Sends SYNC, length, img bytes and checksum; queues the expected results.
  task automatic send_frame(input logic [15:0] n, input logic corrupt);
    logic [7:0]  chk;
    logic [31:0] w;
    chk = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      w = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
      exp_wr.push_back('{a: 8'(i), d: w});
    end
    foreach (img[i]) chk = chk + img[i];
    if (corrupt) chk = chk + 8'h01;
    exp_tx.push_back(corrupt ? 8'h15 : 8'h06);
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (img[i]) send_byte(img[i]);
    send_byte(chk);
  endtask

  task automatic monitor();
    wr_t w;
    logic [7:0] t;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        if (imem_we) begin
          tests_run++;
          if (exp_wr.size() == 0) begin
            failed++;
            $display("FAIL imem_we: unexpected write addr %h data %h", imem_addr, imem_wdata);
          end else begin
            w = exp_wr.pop_front();
            if (imem_addr !== w.a || imem_wdata !== w.d) begin
              failed++;
              $display("FAIL imem_write: got %h/%h expected %h/%h", imem_addr, imem_wdata, w.a, w.d);
            end
          end
        end
        if (tx_valid && tx_ready) begin
          tests_run++;
          if (exp_tx.size() == 0) begin
            failed++;
            $display("FAIL tx: unexpected byte %h", tx_data);
          end else begin
            t = exp_tx.pop_front();
            if (tx_data !== t) begin
              failed++;
              $display("FAIL tx_data: got %h expected %h", tx_data, t);
            end
          end
        end
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    tests_run++;
    if (cpu_reset !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 ||
        busy !== 1'b0 || err_timeout !== 1'b0) begin
      failed++;
      $display("FAIL %s: got rst=%b txv=%b txd=%h we=%b a=%h d=%h busy=%b err=%b expected 1 0 00 0 00 0 0 0",
               tag, cpu_reset, tx_valid, tx_data, imem_we, imem_addr, imem_wdata, busy, err_timeout);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check_reset_vals("reset_hold");
    reset = 1'b0;
    tick(2);
    check_reset_vals("after_reset");
  endtask

  task automatic test_boot_req();
    boot_req = 1'b1;
    tick(1);
    boot_req = 1'b0;
    tests_run++;
    if (cpu_reset !== 1'b1) begin
      failed++;
      $display("FAIL boot_req: cpu_reset got %b expected 1", cpu_reset);
    end
  endtask

  task automatic load_img8();
    img.delete();
    for (int i = 1; i <= 8; i++) img.push_back(8'(8'h11 * i));
  endtask

  task automatic test_ack();
    load_img8();
    send_frame(16'd2, 1'b0);
    check_bit("ack_busy_reply", busy, 1'b1);
    tick(3);
    check_bit("ack_cpu_reset", cpu_reset, 1'b0);
    check_bit("ack_busy_done", busy, 1'b0);
    test_boot_req();
  endtask

  task automatic test_nak();
    load_img8();
    send_frame(16'd2, 1'b1);
    tick(3);
    check_bit("nak_cpu_reset", cpu_reset, 1'b1);
    check_bit("nak_busy", busy, 1'b0);
  endtask

  task automatic test_len_bounds();
    exp_tx.push_back(8'h15);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    tick(3);
    check_bit("oversize_cpu_reset", cpu_reset, 1'b1);
    check_bit("oversize_idle", busy, 1'b0);
    img.delete();
    send_frame(16'd0, 1'b0);
    tick(3);
    check_bit("zero_len_run", cpu_reset, 1'b0);
    test_boot_req();
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(90);
    check_bit("tmo_not_yet_busy", busy, 1'b1);
    check_bit("tmo_not_yet_err", err_timeout, 1'b0);
    tick(20);
    check_bit("tmo_idle", busy, 1'b0);
    check_bit("tmo_err", err_timeout, 1'b1);
    check_bit("tmo_no_tx", tx_valid, 1'b0);
    send_byte(8'hA5);
    check_bit("tmo_err_clear", err_timeout, 1'b0);
    exp_tx.push_back(8'h06);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(3);
    check_bit("tmo_then_run", cpu_reset, 1'b0);
    test_boot_req();
  endtask

  task automatic test_backpressure();
    logic bad;
    bad = 1'b0;
    img.delete();
    for (int i = 1; i <= 4; i++) img.push_back(8'(i));
    tx_ready = 1'b0;
    send_frame(16'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 6 || i == 7) begin
        send_byte(i == 5 ? 8'hA5 : 8'h00);
      end else begin
        tick(1);
      end
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad = 1'b1;
    end
    check_bit("bp_tx_stable", bad, 1'b0);
    check_bit("bp_busy", busy, 1'b1);
    check_bit("bp_cpu_held", cpu_reset, 1'b1);
    tx_ready = 1'b1;
    tick(3);
    check_bit("bp_run", cpu_reset, 1'b0);
    check_bit("bp_txv_drop", tx_valid, 1'b0);
    test_boot_req();
  endtask

  task automatic test_reset_mid();
    exp_wr.push_back('{a: 8'h00, d: 32'h44332211});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    check_bit("mid_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    tick(2);
    reset = 1'b0;
    tick(2);
    check_reset_vals("mid_after");
  endtask

  task automatic test_drain();
    tests_run++;
    if (exp_wr.size() != 0 || exp_tx.size() != 0) begin
      failed++;
      $display("FAIL drain: pending writes %0d tx %0d expected 0 0", exp_wr.size(), exp_tx.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_ack();
    test_nak();
    test_len_bounds();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
